// File: rtl/main_mem.sv
// Line-oriented main memory on a shared tri-state command/data bus: serves
// whole-line reads and writes with a fixed request-to-response latency.
module main_mem #(
    parameter int BUS_SIZE          = 16,
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int CACHE_LINE_SIZE   = 16,
    parameter int MEM_DELAY         = 100
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] mem_address,
    inout  wire  [BUS_SIZE-1:0]                        mem_data,
    inout  wire  [1:0]                                 mem_command
);

    localparam int IDX_W     = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int NUM_LINES = 2 ** IDX_W;
    localparam int BEATS     = (CACHE_LINE_SIZE * 8) / BUS_SIZE;
    localparam int BEAT_W    = $clog2(BEATS);
    localparam int CNT_W     = $clog2(MEM_DELAY + 1);

    localparam logic [1:0]        CMD_RESPONSE = 2'd1;
    localparam logic [1:0]        CMD_READ     = 2'd2;
    localparam logic [1:0]        CMD_WRITE    = 2'd3;
    localparam logic [BEAT_W-1:0] LAST_BEAT    = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  DELAY_LOAD   = CNT_W'(MEM_DELAY - 1);

    typedef logic [BEATS-1:0][BUS_SIZE-1:0] line_t;
    typedef enum logic [2:0] {IDLE, WR_BEATS, WAIT, RD_RESP, WR_RESP} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               op_write_q, op_write_d;
    line_t              line_q, line_d;
    logic [BUS_SIZE-1:0] data_q, data_d;
    logic               drive_cmd_q, drive_cmd_d;
    logic               drive_data_q, drive_data_d;
    logic [NUM_LINES-1:0] valid_q;
    line_t              mem_q [NUM_LINES];

    logic [CACHE_LINE_SIZE-1:0][7:0] rst_pat_s;
    line_t              rd_line_s;
    line_t              wr_line_s;
    logic               mem_we_s;
    logic [BEAT_W-1:0]  nxt_beat_s;

    // Lines never written since reset read back as the address-derived pattern,
    // so reset only has to clear one valid bit per line.
    for (genvar b = 0; b < CACHE_LINE_SIZE; b++) begin : g_pat
        assign rst_pat_s[b] = 8'({addr_q, CACHE_OFFSET_SIZE'(b)}) ^ 8'hA5;
    end

    assign mem_command = drive_cmd_q  ? CMD_RESPONSE : 2'bzz;
    assign mem_data    = drive_data_q ? data_q       : {BUS_SIZE{1'bz}};

    // Storage read view, assembled write line and commit strobe
    always_comb begin
        wr_line_s            = line_q;
        wr_line_s[LAST_BEAT] = mem_data;
        mem_we_s             = (state_q == WR_BEATS) && (beat_q == LAST_BEAT);
        nxt_beat_s           = beat_q + BEAT_W'(1);
        if (valid_q[addr_q]) begin
            rd_line_s = mem_q[addr_q];
        end else begin
            rd_line_s = line_t'(rst_pat_s);
        end
    end

    // Next-state and registered bus-drive decode
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        beat_d       = beat_q;
        op_write_d   = op_write_q;
        line_d       = line_q;
        data_d       = data_q;
        drive_cmd_d  = 1'b0;
        drive_data_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_command == CMD_READ) begin
                    addr_d     = mem_address;
                    cnt_d      = DELAY_LOAD;
                    op_write_d = 1'b0;
                    state_d    = WAIT;
                end else if (mem_command == CMD_WRITE) begin
                    addr_d    = mem_address;
                    line_d[0] = mem_data;
                    beat_d    = BEAT_W'(1);
                    state_d   = WR_BEATS;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_BEATS: begin
                line_d[beat_q] = mem_data;
                if (beat_q == LAST_BEAT) begin
                    cnt_d      = DELAY_LOAD;
                    op_write_d = 1'b1;
                    state_d    = WAIT;
                end else begin
                    beat_d = nxt_beat_s;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (op_write_q) begin
                    drive_cmd_d = 1'b1;
                    state_d     = WR_RESP;
                end else begin
                    drive_cmd_d  = 1'b1;
                    drive_data_d = 1'b1;
                    line_d       = rd_line_s;
                    data_d       = rd_line_s[0];
                    beat_d       = '0;
                    state_d      = RD_RESP;
                end
            end
            RD_RESP: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                end else begin
                    drive_cmd_d  = 1'b1;
                    drive_data_d = 1'b1;
                    beat_d       = nxt_beat_s;
                    data_d       = line_q[nxt_beat_s];
                end
            end
            WR_RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state; reset releases both buses immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            beat_q       <= '0;
            op_write_q   <= 1'b0;
            line_q       <= '0;
            data_q       <= '0;
            drive_cmd_q  <= 1'b0;
            drive_data_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            beat_q       <= beat_d;
            op_write_q   <= op_write_d;
            line_q       <= line_d;
            data_q       <= data_d;
            drive_cmd_q  <= drive_cmd_d;
            drive_data_q <= drive_data_d;
            if (mem_we_s) begin
                valid_q[addr_q] <= 1'b1;
            end
        end
    end

    // Line storage, committed whole on the last write beat
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[addr_q] <= wr_line_s;
        end
    end

endmodule

// File: tb/tb_main_mem.sv
// Self-checking bench for main_mem: table of line transactions plus
// hand-written sequences for ignored commands and mid-transaction reset.
module tb_main_mem;

    localparam int D = 100;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        bit          chk_data;
    } exp_t;

    typedef struct {
        bit                wr;
        logic [14:0]       addr;
        logic [7:0][15:0]  beats;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] addr;
    logic [1:0]  cmd_drv;
    logic        cmd_en;
    logic [15:0] data_drv;
    logic        data_en;
    wire  [15:0] mem_data;
    wire  [1:0]  mem_command;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [15:0] model_mem [int];
    vec_t vecs [10];

    assign mem_data    = data_en ? data_drv : 16'hzzzz;
    assign mem_command = cmd_en  ? cmd_drv  : 2'bzz;

    main_mem #(.MEM_DELAY(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_address (addr),
        .mem_data    (mem_data),
        .mem_command (mem_command)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] model_beat(input int line, input int i);
        int          a;
        logic [7:0]  lo;
        logic [7:0]  hi;
        if (model_mem.exists(line * 8 + i)) return model_mem[line * 8 + i];
        a  = line * 16 + 2 * i;
        lo = 8'(a) ^ 8'hA5;
        hi = 8'(a + 1) ^ 8'hA5;
        return {hi, lo};
    endfunction

    function automatic logic [7:0][15:0] model_line(input logic [14:0] a);
        logic [7:0][15:0] r;
        for (int i = 0; i < 8; i++) r[i[2:0]] = model_beat(int'(a), i);
        return r;
    endfunction

    // Compare whatever the DUT drives this cycle against the scoreboard head
    task automatic monitor();
        exp_t e;
        if (!reset && !cmd_en && mem_command === 2'd1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp cyc=%0d got RESPONSE want none", cyc);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc) begin
                    errors++;
                    $display("FAIL resp_time got cyc=%0d want cyc=%0d", cyc, e.cyc);
                end
                if (e.chk_data) begin
                    checks++;
                    if (mem_data !== e.data) begin
                        errors++;
                        $display("FAIL resp_data cyc=%0d got %h want %h", cyc, mem_data, e.data);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic issue_read(input logic [14:0] a, input logic [7:0][15:0] exp_beats);
        int k;
        k       = cyc + 1;
        addr    = a;
        cmd_drv = 2'd2;
        cmd_en  = 1'b1;
        for (int i = 0; i < 8; i++) sb.push_back('{k + D + i, exp_beats[i[2:0]], 1'b1});
        tick();
        cmd_en = 1'b0;
        addr   = ~a;
    endtask

    task automatic issue_write(input logic [14:0] a, input logic [7:0][15:0] b);
        int k;
        k        = cyc + 1;
        addr     = a;
        cmd_drv  = 2'd3;
        cmd_en   = 1'b1;
        data_en  = 1'b1;
        data_drv = b[0];
        tick();
        cmd_en = 1'b0;
        addr   = ~a;
        for (int i = 1; i < 8; i++) begin
            data_drv = b[i[2:0]];
            tick();
        end
        data_en = 1'b0;
        sb.push_back('{k + 7 + D, 16'h0000, 1'b0});
        for (int i = 0; i < 8; i++) model_mem[int'(a) * 8 + i] = b[i[2:0]];
    endtask

    // Wait for all expected responses, then one more cycle covering the release edge
    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < D + 40) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL resp_timeout got %0d pending want 0", sb.size());
            sb.delete();
        end
        tick();
    endtask

    initial begin
        logic [7:0][15:0] beats;
        int               n;
        logic [15:0]      live_beat;

        reset = 1'b1; cmd_en = 1'b0; data_en = 1'b0;
        cmd_drv = 2'd0; data_drv = 16'h0000; addr = 15'h0000;

        vecs[0] = '{1'b0, 15'h0000, {16'hAAAB, 16'hA8A9, 16'hAEAF, 16'hACAD,
                                      16'hA2A3, 16'hA0A1, 16'hA6A7, 16'hA4A5}};
        vecs[1] = '{1'b1, 15'h7FFF, {16'h0807, 16'h0706, 16'h0605, 16'h0504,
                                      16'h0403, 16'h0302, 16'h0201, 16'h0100}};
        vecs[2] = '{1'b0, 15'h7FFF, vecs[1].beats};
        vecs[3] = '{1'b0, 15'h1234, model_line(15'h1234)};
        vecs[4] = '{1'b1, 15'h0ABC, {16'h1357, 16'h2468, 16'hBEEF, 16'hDEAD,
                                      16'h0F0F, 16'hF0F0, 16'h5A5A, 16'hC3C3}};
        vecs[5] = '{1'b0, 15'h0ABC, vecs[4].beats};
        vecs[6] = '{1'b0, 15'h0ABD, model_line(15'h0ABD)};
        vecs[7] = '{1'b1, 15'h0000, {16'h0000, 16'hFFFF, 16'h8001, 16'h7FFE,
                                      16'h00FF, 16'hFF00, 16'h1234, 16'hFFFF}};
        vecs[8] = '{1'b0, 15'h0000, vecs[7].beats};
        vecs[9] = '{1'b0, 15'h7FFF, vecs[1].beats};

        repeat (3) @(negedge clk);
        checks++;
        if (mem_command === 2'd1) begin
            errors++;
            $display("FAIL reset_cmd got RESPONSE want released");
        end
        reset = 1'b0;

        // Back-to-back table transactions, the first on the edge after reset release
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].wr) issue_write(vecs[v].addr, vecs[v].beats);
            else            issue_read(vecs[v].addr, vecs[v].beats);
            drain();
        end

        // WRITE during a read's WAIT must be ignored
        issue_read(15'h0ABD, model_line(15'h0ABD));
        repeat (5) tick();
        addr = 15'h0ABD; cmd_drv = 2'd3; cmd_en = 1'b1; data_en = 1'b1; data_drv = 16'hDEAD;
        tick();
        cmd_en = 1'b0;
        repeat (7) tick();
        data_en = 1'b0;
        drain();
        issue_read(15'h0ABD, model_line(15'h0ABD));
        drain();

        // NOP and RESPONSE in IDLE are no-ops
        cmd_en = 1'b1; cmd_drv = 2'd0; addr = 15'h0123;
        tick();
        cmd_drv = 2'd1;
        tick();
        cmd_en = 1'b0;
        repeat (D + 12) tick();

        // Reset in the middle of a read response releases the buses at once
        issue_read(15'h1234, model_line(15'h1234));
        live_beat = model_beat(32'h1234, 2);
        n = 0;
        while (sb.size() > 5 && n < D + 20) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 5) begin
            errors++;
            $display("FAIL mid_read_progress got %0d pending want 5", sb.size());
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (mem_command === 2'd1 || mem_data === live_beat) begin
            errors++;
            $display("FAIL async_release_rd got cmd=%h data=%h want released", mem_command, mem_data);
        end
        sb.delete();
        model_mem.delete();
        repeat (2) tick();
        reset = 1'b0;

        // Reset after write beat 3: no response, line keeps its reset contents
        beats = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h9999};
        addr = 15'h2222; cmd_drv = 2'd3; cmd_en = 1'b1; data_en = 1'b1; data_drv = beats[0];
        tick();
        cmd_en = 1'b0;
        for (int i = 1; i < 4; i++) begin
            data_drv = beats[i[2:0]];
            tick();
        end
        data_drv = beats[4];
        #2 reset = 1'b1;
        #1;
        checks++;
        if (mem_command === 2'd1) begin
            errors++;
            $display("FAIL async_release_wr got RESPONSE want released");
        end
        repeat (2) tick();
        data_en = 1'b0;
        reset = 1'b0;
        repeat (D + 20) tick();
        issue_read(15'h2222, model_line(15'h2222));
        drain();

        // Storage re-initialised by reset
        issue_read(15'h7FFF, model_line(15'h7FFF));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
